spi_slave: RTL

- Serial front end of the SPI project. Sits between the external SPI master (ss_n/mosi/miso) and the single-port RAM command interface.
- Deserialises each MOSI frame into a 10-bit command word (cmd[1:0] + byte) and presents it with a one-cycle rx_valid pulse.
- For read-data commands, waits for the RAM's tx_valid, then serialises the returned byte MSB-first on miso.
- The SPI serial clock is clk; mosi, ss_n and miso are all sampled and driven on the clk rising edge.

---
 rtl/spi_slave.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
`default_nettype none
// spi_slave: SPI serial front end. Deserialises MOSI command frames and shifts RAM read bytes out on MISO.
// Optional macro SPI_FRAME_ERR_EN adds a one-cycle frame_err pulse on aborted frames.
module spi_slave #(
  parameter int RX_W = 10,
  parameter int TX_W = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ss_n,
  input  logic            mosi,
  output logic            miso,
  output logic [RX_W-1:0] rx_data,
  output logic            rx_valid,
  input  logic [TX_W-1:0] tx_data,
  input  logic            tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic            frame_err
`endif
);

  localparam int CNT_W = $clog2(RX_W + 1);
  localparam int TXC_W = $clog2(TX_W + 1);
  localparam logic [CNT_W-1:0] RX_LAST     = CNT_W'(RX_W - 1);
  localparam logic [CNT_W-1:0] RX_DONE     = CNT_W'(RX_W);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [TXC_W-1:0] TX_DONE     = TXC_W'(TX_W);
  localparam logic [TXC_W-1:0] TXC_ONE     = TXC_W'(1);
  localparam logic [1:0]       CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHK_CMD = 2'd1,
    WRITE   = 2'd2,
    READ    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // The last payload bit goes straight into rx_data, so only RX_W-1 bits need holding.
  logic [RX_W-2:0]   rx_shift_q, rx_shift_d;
  logic [RX_W-1:0]   rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [TX_W-1:0]   tx_shift_q, tx_shift_d;
  logic              tx_captured_q, tx_captured_d;
  logic [TXC_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic              miso_q, miso_d;
  logic              read_resp;
`ifdef SPI_FRAME_ERR_EN
  logic              frame_err_q, frame_err_d;
`endif

  assign read_resp = (state_q == READ) && (cnt_q == RX_DONE) &&
                     (rx_data_q[RX_W-1 -: 2] == CMD_RD_DATA);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_shift_d    = tx_shift_q;
    tx_captured_d = tx_captured_q;
    tx_cnt_d      = tx_cnt_q;
    miso_d        = 1'b0;
`ifdef SPI_FRAME_ERR_EN
    frame_err_d   = 1'b0;
`endif

    if (state_q != IDLE && ss_n) begin
      state_d       = IDLE;
      cnt_d         = '0;
      rx_shift_d    = '0;
      tx_shift_d    = '0;
      tx_captured_d = 1'b0;
      tx_cnt_d      = '0;
`ifdef SPI_FRAME_ERR_EN
      if (state_q == WRITE || state_q == READ) begin
        if (cnt_q != RX_DONE) begin
          frame_err_d = 1'b1;
        end else if (read_resp && tx_cnt_q != TX_DONE) begin
          frame_err_d = 1'b1;
        end
      end
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!ss_n) state_d = CHK_CMD;
        end
        CHK_CMD: begin
          state_d = mosi ? READ : WRITE;
          cnt_d   = '0;
        end
        WRITE, READ: begin
          if (cnt_q != RX_DONE) begin
            rx_shift_d = {rx_shift_q[RX_W-3:0], mosi};
            cnt_d      = cnt_q + CNT_ONE;
            if (cnt_q == RX_LAST) begin
              rx_data_d  = {rx_shift_q, mosi};
              rx_valid_d = 1'b1;
            end
          end else if (read_resp) begin
            // Capture once, then shift out on the following TX_W cycles.
            if (!tx_captured_q) begin
              if (tx_valid) begin
                tx_shift_d    = tx_data;
                tx_captured_d = 1'b1;
              end
            end else if (tx_cnt_q != TX_DONE) begin
              miso_d     = tx_shift_q[TX_W-1];
              tx_shift_d = tx_shift_q << 1;
              tx_cnt_d   = tx_cnt_q + TXC_ONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_shift_q    <= '0;
      tx_captured_q <= 1'b0;
      tx_cnt_q      <= '0;
      miso_q        <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_shift_q    <= tx_shift_d;
      tx_captured_q <= tx_captured_d;
      tx_cnt_q      <= tx_cnt_d;
      miso_q        <= miso_d;
`ifdef SPI_FRAME_ERR_EN
      frame_err_q   <= frame_err_d;
`endif
    end
  end

  assign miso     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`ifdef SPI_FRAME_ERR_EN
  assign frame_err = frame_err_q;
`endif

endmodule
`default_nettype wire
